bcd_serial_add_ctrl: RTL

//  Sequences a single-digit BCD adder over an N-digit packed-BCD operand pair, one digit per clock, LSD first.

---
 rtl/bcd_serial_add_ctrl_pkg.sv | 13 +
 rtl/bcd_serial_add_ctrl_if.sv | 25 ++
 rtl/bcd_serial_add_ctrl_digit_add.sv | 23 ++
 rtl/bcd_serial_add_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared constants, FSM state type and digit validity helper for the serial BCD adder.
package bcd_pkg;

  localparam int DIGIT_W  = 4;
  localparam int BCD_BASE = 10;

  typedef enum logic [1:0] {IDLE, ADD, DONE} bcd_state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
    return digit < DIGIT_W'(BCD_BASE);
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Requester <-> controller bus: operands and start in, packed-BCD result and status out.
interface bcd_serial_add_ctrl_if #(
  parameter int N_DIGITS = 4
);

  logic                  start;
  logic [4*N_DIGITS-1:0] a;
  logic [4*N_DIGITS-1:0] b;
  logic [4*N_DIGITS-1:0] sum;
  logic                  cout;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, a, b,
    input  sum, cout, busy, done, err
  );

  modport slave (
    input  start, a, b,
    output sum, cout, busy, done, err
  );

endinterface

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// One decimal digit position: binary add of two digits plus carry, folded back to base 10.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               cin,
  output logic [DIGIT_W-1:0] units,
  output logic               cout
);

  logic [DIGIT_W:0] s;
  logic [DIGIT_W:0] rem;

  // Non-BCD digits can push s past 19; carry is clamped to one bit regardless.
  always_comb begin
    s     = (DIGIT_W+1)'(a_d) + (DIGIT_W+1)'(b_d) + (DIGIT_W+1)'(cin);
    rem   = s % (DIGIT_W+1)'(BCD_BASE);
    units = rem[DIGIT_W-1:0];
    cout  = s >= (DIGIT_W+1)'(BCD_BASE);
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial N-digit packed-BCD adder controller, one digit per clock, LSD first.
// Optional macro BCD_CHECK_EN flags operands containing digits above 9 on err.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_serial_add_ctrl_if.slave bus,
  output bcd_state_t           state_dbg_o
);

  localparam int W     = DIGIT_W * N_DIGITS;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  // Handshake: start is a one-cycle request honoured only in IDLE (otherwise dropped);
  // busy covers the digit cycles; done is a one-cycle strobe qualifying sum/cout.
  bcd_state_t         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic [DIGIT_W-1:0] units;
  logic               dig_cout;

  assign a_dig = a_q[DIGIT_W*idx_q +: DIGIT_W];
  assign b_dig = b_q[DIGIT_W*idx_q +: DIGIT_W];

  bcd_digit_add u_digit (
    .a_d   (a_dig),
    .b_d   (b_dig),
    .cin   (carry_q),
    .units (units),
    .cout  (dig_cout)
  );

`ifdef BCD_CHECK_EN
  logic err_q;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!is_bcd(bus.a[DIGIT_W*i +: DIGIT_W]) || !is_bcd(bus.b[DIGIT_W*i +: DIGIT_W])) begin
        bad_digit = 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
`ifdef BCD_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ADD;
`ifdef BCD_CHECK_EN
            err_q   <= bad_digit;
`endif
          end
        end
        ADD: begin
          sum_q[DIGIT_W*idx_q +: DIGIT_W] <= units;
          carry_q <= dig_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          cout_q  <= carry_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign state_dbg_o = state_q;

endmodule
